// File: rtl/wavepool_mux_pkg.sv
// Shared constants and elaboration helpers for the wavepool entry selector.
package wavepool_mux_pkg;

  localparam int WP_NUM_IN = 40;
  localparam int WP_WIDTH  = 35;
  localparam int WP_SEL_W  = 6;
  localparam int WP_RADIX  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ngrp(input int num_in, input int radix);
    return (num_in + radix - 1) / radix;
  endfunction

  // Width of the group index left in the select after the in-group bits.
  function automatic int gsel_w(input int sel_w, input int radix);
    return sel_w - clog2(radix);
  endfunction

  localparam int WP_NGRP   = ngrp(WP_NUM_IN, WP_RADIX);
  localparam int WP_GSEL_W = gsel_w(WP_SEL_W, WP_RADIX);

endpackage

// File: rtl/mux_pipe_stage.sv
// Single valid/ready register slice; payload loads only when a valid word advances.
module mux_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid <= 1'b0;
    else if (in_ready)
      out_valid <= in_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_data <= '0;
    else if (in_valid && in_ready)
      out_data <= in_data;
  end

endmodule

// File: rtl/mux_nxw_to_1xw_pipe.sv
// Two-stage pipelined NUM_IN x WIDTH to 1 x WIDTH selector with valid/ready flow
// control; out-of-range selects are flagged and return zero data.
module mux_nxw_to_1xw_pipe
  import wavepool_mux_pkg::*;
#(
  parameter int NUM_IN = WP_NUM_IN,
  parameter int WIDTH  = WP_WIDTH,
  parameter int SEL_W  = WP_SEL_W,
  parameter int RADIX  = WP_RADIX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_select,
  output logic                    out_err
);

  localparam int NG   = ngrp(NUM_IN, RADIX);
  localparam int LR   = clog2(RADIX);
  localparam int GW   = gsel_w(SEL_W, RADIX);
  localparam int PADW = (NG*RADIX - NUM_IN) * WIDTH;
  localparam int P1W  = NG*WIDTH + SEL_W + 1;
  localparam int P2W  = WIDTH + SEL_W + 1;

  // Entries beyond NUM_IN in a partial last group read as zero.
  logic [NG*RADIX*WIDTH-1:0] ent_flat;
  if (PADW > 0) begin : g_pad
    assign ent_flat = {{PADW{1'b0}}, in_data};
  end else begin : g_nopad
    assign ent_flat = in_data;
  end

  logic [LR-1:0]       lo_sel;
  logic [NG*WIDTH-1:0] grp_d;
  logic                err_d;

  assign lo_sel = in_select[LR-1:0];
  assign err_d  = (int'(in_select) >= NUM_IN);

  always_comb begin
    grp_d = '0;
    for (int g = 0; g < NG; g++) begin
      for (int r = 0; r < RADIX; r++) begin
        if (int'(lo_sel) == r)
          grp_d[g*WIDTH +: WIDTH] = ent_flat[(g*RADIX + r)*WIDTH +: WIDTH];
      end
    end
  end

  logic                s1_valid;
  logic                adv2;
  logic [P1W-1:0]      s1_pl;
  logic [NG*WIDTH-1:0] s1_grp;
  logic [SEL_W-1:0]    s1_sel;
  logic                s1_err;

  mux_pipe_stage #(.PW(P1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({grp_d, in_select, err_d}),
    .out_valid (s1_valid),
    .out_ready (adv2),
    .out_data  (s1_pl)
  );

  assign {s1_grp, s1_sel, s1_err} = s1_pl;

  logic [GW-1:0]    hi_sel;
  logic [WIDTH-1:0] sel_d;

  assign hi_sel = s1_sel[SEL_W-1:LR];

  always_comb begin
    sel_d = '0;
    for (int g = 0; g < NG; g++) begin
      if (int'(hi_sel) == g)
        sel_d = s1_grp[g*WIDTH +: WIDTH];
    end
    if (s1_err)
      sel_d = '0;
  end

  logic [P2W-1:0] s2_pl;

  mux_pipe_stage #(.PW(P2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (adv2),
    .in_data   ({sel_d, s1_sel, s1_err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_pl)
  );

  assign {out_data, out_select, out_err} = s2_pl;

endmodule

// File: tb/tb_mux_nxw_to_1xw_pipe.sv
// Bench for mux_nxw_to_1xw_pipe: queue-based reference model plus directed and random stimulus.
module tb_mux_nxw_to_1xw_pipe;

  localparam int N  = 40, W  = 35, SW  = 6, R  = 8;
  localparam int NS = 5,  WS = 8,  SWS = 3, RS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [N*W-1:0] in_data;
  logic [SW-1:0] in_select, out_select;
  logic [W-1:0]  out_data;

  logic            in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_err_s;
  logic [NS*WS-1:0] in_data_s;
  logic [SWS-1:0]  in_select_s, out_select_s;
  logic [WS-1:0]   out_data_s;

  always #5 clk = ~clk;

  mux_nxw_to_1xw_pipe #(.NUM_IN(N), .WIDTH(W), .SEL_W(SW), .RADIX(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_select(in_select), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_select(out_select), .out_err(out_err));

  mux_nxw_to_1xw_pipe #(.NUM_IN(NS), .WIDTH(WS), .SEL_W(SWS), .RADIX(RS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .in_select(in_select_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_data(out_data_s), .out_select(out_select_s), .out_err(out_err_s));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic pattern_mode = 1'b1;
  logic to_err = 1'b0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          e;
    int            acc;
  } item_t;

  item_t q[$];
  int    qs[$];
  int    avail;
  int    ns_out = 0;
  logic  prev_hold = 1'b0;
  logic [W-1:0]  prev_d;
  logic [SW-1:0] prev_s;
  logic          prev_e;
  logic  to_seen = 1'b0;
  logic  final_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Single compare process for both instances, sampled mid-cycle.
  always @(negedge clk) begin
    item_t it;
    logic  exp_v;
    int    e;
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_out_valid_s", 64'(out_valid_s), 64'd0);
      q.delete();
      qs.delete();
      prev_hold = 1'b0;
    end else begin
      exp_v = (q.size() > 0) && (cyc >= avail);
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("in_ready", 64'(in_ready), 64'((q.size() - int'(exp_v && out_ready)) < 2));
      if (out_valid && q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_select", 64'(out_select), 64'(q[0].s));
        chk("out_err", 64'(out_err), 64'(q[0].e));
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({out_data, out_select, out_err}), 64'({prev_d, prev_s, prev_e}));
      end
      prev_hold = out_valid && !out_ready;
      prev_d = out_data; prev_s = out_select; prev_e = out_err;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() > 0)
          avail = (q[0].acc + 2 > cyc + 1) ? q[0].acc + 2 : cyc + 1;
      end
      if (in_valid && in_ready) begin
        it.s = in_select;
        it.e = (int'(in_select) >= N);
        it.d = it.e ? '0 : in_data[int'(in_select)*W +: W];
        it.acc = cyc;
        if (pattern_mode)
          chk("model_pin", 64'(it.d), it.e ? 64'd0 : 64'(int'(in_select)*3 + 1));
        if (q.size() == 0) avail = cyc + 2;
        q.push_back(it);
      end

      if (out_valid_s) begin
        if (qs.size() == 0) begin
          chk("s_spurious", 64'd1, 64'd0);
        end else begin
          e = qs.pop_front();
          chk("s_err", 64'(out_err_s), 64'(e >= NS));
          chk("s_data", 64'(out_data_s), (e < NS) ? 64'(8'hA0 + e) : 64'd0);
          chk("s_select", 64'(out_select_s), 64'(e));
          ns_out++;
        end
      end
      if (in_valid_s && in_ready_s) qs.push_back(int'(in_select_s));
    end
    if (to_err && !to_seen) begin
      chk("accept_timeout", 64'd1, 64'd0);
      to_seen = 1'b1;
    end
    if (done && !final_done) begin
      chk("s_count", 64'(ns_out), 64'd8);
      chk("drained", 64'(q.size() + qs.size()), 64'd0);
      final_done = 1'b1;
    end
  end

  task automatic set_pattern();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i*3 + 1);
  endtask

  task automatic send(input int sel);
    int k;
    in_valid = 1'b1;
    in_select = SW'(sel);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) to_err = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_s(input int sel);
    int k;
    in_valid_s = 1'b1;
    in_select_s = SWS'(sel);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready_s) break;
    end
    if (k == 50) to_err = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_valid_s = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    in_valid = 1'b0; in_select = '0; out_ready = 1'b1;
    in_valid_s = 1'b0; in_select_s = '0; out_ready_s = 1'b1;
    set_pattern();
    for (int i = 0; i < NS; i++) in_data_s[i*WS +: WS] = WS'(8'hA0 + i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    for (int i = 0; i < N; i++) send(i);
    idle(4);

    send(40); send(63); send(39);
    idle(4);

    out_ready = 1'b0;
    fork
      begin repeat (6) @(posedge clk); #1 out_ready = 1'b1; end
      begin for (int i = 10; i < 16; i++) send(i); end
    join
    idle(5);

    send(7);
    in_data[7*W +: W] = W'(35'h7_FFFF_FFFF);
    idle(4);
    set_pattern();

    send(1); send(2); send(3);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    pattern_mode = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_select = SW'($urandom_range(0, 63));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        for (int e = 0; e < N; e++) in_data[e*W +: W] = W'({$urandom(), $urandom()});
    end
    out_ready = 1'b1;
    idle(4);

    for (int i = 0; i < 8; i++) send_s(i);
    idle(6);

    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
